d1_ctrl: RTL and testbench

D1_CTRL -- requirements
Module: d1_ctrl

---
 rtl/d1_pkg.sv | 24 ++
 rtl/d1_bank_mux.sv | 71 +++++++
 rtl/d1_ctrl.sv | 160 ++++++++++++++++
 tb/tb_d1_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d1_pkg.sv
// Shared types and widths for the d1 list-distance controller slice.
package d1_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT_A,
        SORT_B,
        CLR_SUM,
        SUM,
        FINISH
    } state_t;

    // One bank's write/address port as driven by the controller.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } bank_port_t;

endpackage

// File: rtl/d1_bank_mux.sv
// Per-state ownership of the two list banks: loader, sorter, summer or idle.
module d1_bank_mux
    import d1_pkg::*;
(
    input  logic              wr_en,
    input  state_t            state,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_fire,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [ADDR_W-1:0] sort_addr,
    input  logic [DATA_W-1:0] sort_wdata,
    input  logic              sort_we,
    input  logic [31:0]       sum_addr1,
    input  logic [31:0]       sum_addr2,
    input  logic [DATA_W-1:0] mema_rdata,
    input  logic [DATA_W-1:0] memb_rdata,
    output bank_port_t        bank_a,
    output bank_port_t        bank_b,
    output logic [DATA_W-1:0] sort_rdata,
    output logic [DATA_W-1:0] sum_data1,
    output logic [DATA_W-1:0] sum_data2
);

    // Summer addresses are 32 bits wide but the banks only decode the low half.
    logic unused_sum_addr_hi;
    assign unused_sum_addr_hi = ^{sum_addr1[31:ADDR_W], sum_addr2[31:ADDR_W]};

    always_comb begin
        bank_a     = '0;
        bank_b     = '0;
        sort_rdata = '0;
        sum_data1  = '0;
        sum_data2  = '0;
        case (state)
            LOAD: begin
                bank_a.addr  = load_addr;
                bank_a.wdata = in_a;
                bank_a.we    = load_fire;
                bank_b.addr  = load_addr;
                bank_b.wdata = in_b;
                bank_b.we    = load_fire;
            end
            SORT_A: begin
                bank_a.addr  = sort_addr;
                bank_a.wdata = sort_wdata;
                bank_a.we    = sort_we;
                sort_rdata   = mema_rdata;
            end
            SORT_B: begin
                bank_b.addr  = sort_addr;
                bank_b.wdata = sort_wdata;
                bank_b.we    = sort_we;
                sort_rdata   = memb_rdata;
            end
            SUM: begin
                bank_a.addr = sum_addr1[ADDR_W-1:0];
                bank_b.addr = sum_addr2[ADDR_W-1:0];
                sum_data1   = mema_rdata;
                sum_data2   = memb_rdata;
            end
            default: ;
        endcase
        // Held reset cuts writes immediately, even before the state register clears.
        if (!wr_en) begin
            bank_a.we = 1'b0;
            bank_b.we = 1'b0;
        end
    end

endmodule

// File: rtl/d1_ctrl.sv
// Job controller: load two lists, sort each bank, then sum pairwise distances.
module d1_ctrl
    import d1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [ADDR_W-1:0] mema_addr,
    output logic [DATA_W-1:0] mema_wdata,
    output logic              mema_we,
    input  logic [DATA_W-1:0] mema_rdata,
    output logic [ADDR_W-1:0] memb_addr,
    output logic [DATA_W-1:0] memb_wdata,
    output logic              memb_we,
    input  logic [DATA_W-1:0] memb_rdata,
    output logic              sort_go,
    output logic              sort_sel,
    output logic [ADDR_W-1:0] sort_len,
    input  logic              sort_done,
    input  logic [ADDR_W-1:0] sort_addr,
    input  logic [DATA_W-1:0] sort_wdata,
    input  logic              sort_we,
    output logic [DATA_W-1:0] sort_rdata,
    output logic              sum_rst_n,
    output logic              sum_go,
    output logic [ADDR_W-1:0] sum_length,
    input  logic              sum_done,
    input  logic [31:0]       sum_addr1,
    input  logic [31:0]       sum_addr2,
    output logic [DATA_W-1:0] sum_data1,
    output logic [DATA_W-1:0] sum_data2,
    input  logic [DATA_W-1:0] sum_total
);

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] k;
    logic              load_fire;
    bank_port_t        bank_a;
    bank_port_t        bank_b;

    assign load_fire = (state == LOAD) && in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            in_ready   <= 1'b0;
            sort_go    <= 1'b0;
            sort_sel   <= 1'b0;
            sort_len   <= '0;
            sum_rst_n  <= 1'b0;
            sum_go     <= 1'b0;
            sum_length <= '0;
            len_q      <= '0;
            k          <= '0;
        end else begin
            sort_go   <= 1'b0;
            sum_go    <= 1'b0;
            sum_rst_n <= 1'b1;
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        len_q      <= length;
                        sort_len   <= length;
                        sum_length <= length - ADDR_W'(1);
                        k          <= '0;
                        if (length == '0) begin
                            // Empty job completes at once with a zero distance.
                            state  <= FINISH;
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        k <= k + ADDR_W'(1);
                        if (k == len_q - ADDR_W'(1)) begin
                            state    <= SORT_A;
                            in_ready <= 1'b0;
                            sort_go  <= 1'b1;
                            sort_sel <= 1'b0;
                        end
                    end
                end
                SORT_A: begin
                    if (sort_done) begin
                        state    <= SORT_B;
                        sort_go  <= 1'b1;
                        sort_sel <= 1'b1;
                    end
                end
                SORT_B: begin
                    if (sort_done) begin
                        state     <= CLR_SUM;
                        sum_rst_n <= 1'b0;
                    end
                end
                CLR_SUM: begin
                    state  <= SUM;
                    sum_go <= 1'b1;
                end
                SUM: begin
                    if (sum_done) begin
                        state  <= FINISH;
                        result <= sum_total;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    d1_bank_mux u_bank_mux (
        .wr_en      (reset),
        .state      (state),
        .load_addr  (k),
        .load_fire  (load_fire),
        .in_a       (in_a),
        .in_b       (in_b),
        .sort_addr  (sort_addr),
        .sort_wdata (sort_wdata),
        .sort_we    (sort_we),
        .sum_addr1  (sum_addr1),
        .sum_addr2  (sum_addr2),
        .mema_rdata (mema_rdata),
        .memb_rdata (memb_rdata),
        .bank_a     (bank_a),
        .bank_b     (bank_b),
        .sort_rdata (sort_rdata),
        .sum_data1  (sum_data1),
        .sum_data2  (sum_data2)
    );

    assign mema_addr  = bank_a.addr;
    assign mema_wdata = bank_a.wdata;
    assign mema_we    = bank_a.we;
    assign memb_addr  = bank_b.addr;
    assign memb_wdata = bank_b.wdata;
    assign memb_we    = bank_b.we;

endmodule

// File: tb/tb_d1_ctrl.sv
// Directed bench for d1_ctrl with behavioural banks, sorter and distance summer.
`timescale 1ns/1ps
module tb_d1_ctrl;
    import d1_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, busy, done, in_valid, in_ready;
    logic [15:0] length;
    logic [31:0] result, in_a, in_b;
    logic [15:0] mema_addr, memb_addr;
    logic [31:0] mema_wdata, memb_wdata, mema_rdata, memb_rdata;
    logic        mema_we, memb_we;
    logic        sort_go, sort_sel, sort_done, sort_we;
    logic [15:0] sort_len, sort_addr;
    logic [31:0] sort_wdata, sort_rdata;
    logic        sum_rst_n, sum_go, sum_done;
    logic [15:0] sum_length;
    logic [31:0] sum_addr1, sum_addr2, sum_data1, sum_data2, sum_total;

    d1_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .busy(busy), .done(done), .result(result),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mema_addr(mema_addr), .mema_wdata(mema_wdata), .mema_we(mema_we), .mema_rdata(mema_rdata),
        .memb_addr(memb_addr), .memb_wdata(memb_wdata), .memb_we(memb_we), .memb_rdata(memb_rdata),
        .sort_go(sort_go), .sort_sel(sort_sel), .sort_len(sort_len), .sort_done(sort_done),
        .sort_addr(sort_addr), .sort_wdata(sort_wdata), .sort_we(sort_we), .sort_rdata(sort_rdata),
        .sum_rst_n(sum_rst_n), .sum_go(sum_go), .sum_length(sum_length), .sum_done(sum_done),
        .sum_addr1(sum_addr1), .sum_addr2(sum_addr2), .sum_data1(sum_data1), .sum_data2(sum_data2),
        .sum_total(sum_total)
    );

    int total = 0;
    int bad = 0;

    // Banks with combinational read.
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    assign mema_rdata = mem_a[mema_addr[3:0]];
    assign memb_rdata = mem_b[memb_addr[3:0]];
    always @(posedge clk) begin
        if (mema_we) mem_a[mema_addr[3:0]] <= mema_wdata;
        if (memb_we) mem_b[memb_addr[3:0]] <= memb_wdata;
    end

    // Loader-write log: writes that happen while the loader owns the banks.
    int          load_cnt_a = 0, load_cnt_b = 0;
    logic [15:0] load_log_a [0:63];
    logic [15:0] load_log_b [0:63];
    always @(posedge clk) begin
        if (mema_we && in_ready && load_cnt_a < 64) begin load_log_a[6'(load_cnt_a)] = mema_addr; load_cnt_a++; end
        if (memb_we && in_ready && load_cnt_b < 64) begin load_log_b[6'(load_cnt_b)] = memb_addr; load_cnt_b++; end
    end

    // Behavioural sorter: read N words, sort locally, write them back, pulse done.
    int          s_phase = 0, s_idx = 0, s_len = 0;
    logic        s_sel = 1'b0;
    logic        s_done_r = 1'b0;
    logic        spur_done;
    logic [31:0] s_buf [0:15];
    logic [31:0] s_tmp;
    assign sort_done  = s_done_r | spur_done;
    assign sort_addr  = 16'(s_idx);
    assign sort_we    = (s_phase == 2);
    assign sort_wdata = s_buf[s_idx[3:0]];
    always @(posedge clk) begin
        if (!reset) begin
            s_phase  <= 0;
            s_idx    <= 0;
            s_done_r <= 1'b0;
        end else begin
            s_done_r <= 1'b0;
            case (s_phase)
                0: if (sort_go) begin
                    s_len <= int'(sort_len); s_sel <= sort_sel; s_idx <= 0; s_phase <= 1;
                end
                1: begin
                    s_buf[s_idx[3:0]] = sort_rdata;
                    if (s_idx == s_len - 1) begin
                        for (int i = 0; i < s_len; i++)
                            for (int j = 0; j + 1 < s_len - i; j++)
                                if (s_buf[4'(j)] > s_buf[4'(j+1)]) begin
                                    s_tmp = s_buf[4'(j)]; s_buf[4'(j)] = s_buf[4'(j+1)]; s_buf[4'(j+1)] = s_tmp;
                                end
                        s_idx <= 0; s_phase <= 2;
                    end else s_idx <= s_idx + 1;
                end
                2: if (s_idx == s_len - 1) begin s_phase <= 3; s_done_r <= 1'b1; end
                   else s_idx <= s_idx + 1;
                default: s_phase <= 0;
            endcase
        end
    end

    // Behavioural summer: total of |a[i]-b[i]| for i = 0..sum_length.
    int          m_phase = 0, m_idx = 0;
    logic [31:0] m_total = '0;
    logic        m_done_r = 1'b0;
    assign sum_addr1 = 32'(m_idx);
    assign sum_addr2 = 32'(m_idx);
    assign sum_done  = m_done_r;
    assign sum_total = m_total;
    function automatic logic [31:0] absdiff(input logic [31:0] x, input logic [31:0] y);
        return (x > y) ? x - y : y - x;
    endfunction
    always @(posedge clk) begin
        m_done_r <= 1'b0;
        if (!sum_rst_n) begin
            m_phase <= 0; m_idx <= 0; m_total <= '0;
        end else begin
            case (m_phase)
                0: if (sum_go) begin m_idx <= 0; m_phase <= 1; end
                1: begin
                    m_total <= m_total + absdiff(sum_data1, sum_data2);
                    if (m_idx == int'(sum_length)) begin m_phase <= 2; m_done_r <= 1'b1; end
                    else m_idx <= m_idx + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Event monitors and the bank-ownership watch.
    int          sort_go_cnt = 0, sum_go_cnt = 0, in_ready_cnt = 0, clr_cnt = 0, we_viol = 0;
    logic [15:0] last_sort_len = '0, last_sum_len = '0;
    logic [1:0]  sel_hist = '0;
    always @(negedge clk) begin
        if (sort_go) begin sort_go_cnt++; last_sort_len = sort_len; sel_hist = {sel_hist[0], sort_sel}; end
        if (sum_go) begin sum_go_cnt++; last_sum_len = sum_length; end
        if (in_ready) in_ready_cnt++;
        if (reset && !sum_rst_n) clr_cnt++;
        if (mema_we && !(in_ready || (s_phase == 2 && !s_sel))) we_viol++;
        if (memb_we && !(in_ready || (s_phase == 2 && s_sel))) we_viol++;
        if (m_phase == 1 && (mema_we || memb_we)) we_viol++;
        if (!reset && (mema_we || memb_we)) we_viol++;
    end

    logic [31:0] va [0:15];
    logic [31:0] vb [0:15];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input int n);
        start = 1'b1; length = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_a = va[4'(i)]; in_b = vb[4'(i)];
            tick();
            if (gap && i != n - 1) begin in_valid = 1'b0; tick(); end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (done !== 1'b1 && c < 3000) begin tick(); c++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL %s_timeout: done=%b want 1", tag, done); end
    endtask

    task automatic load_main();
        va[0] = 3; va[1] = 4; va[2] = 2; va[3] = 1; va[4] = 3; va[5] = 3;
        vb[0] = 4; vb[1] = 3; vb[2] = 5; vb[3] = 3; vb[4] = 9; vb[5] = 3;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if ({sort_go, sum_go} !== 2'b00) begin bad++; $display("FAIL reset_go: got %b want 00", {sort_go, sum_go}); end
        total++; if (sum_rst_n !== 1'b0) begin bad++; $display("FAIL reset_sum_rst_n: got %b want 0", sum_rst_n); end
        total++; if ({mema_we, memb_we} !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", {mema_we, memb_we}); end
        reset = 1'b1;
        tick();
        total++; if (sum_rst_n !== 1'b1) begin bad++; $display("FAIL idle_sum_rst_n: got %b want 1", sum_rst_n); end
        total++; if (mema_addr !== 16'd0 || memb_addr !== 16'd0) begin bad++; $display("FAIL idle_addr: got %0d/%0d want 0/0", mema_addr, memb_addr); end
    endtask

    task automatic test_main_job();
        int b_sort = sort_go_cnt, b_sum = sum_go_cnt, b_clr = clr_cnt;
        logic [31:0] ea [0:5];
        logic [31:0] eb [0:5];
        bit ok = 1'b1;
        ea[0] = 1; ea[1] = 2; ea[2] = 3; ea[3] = 3; ea[4] = 3; ea[5] = 4;
        eb[0] = 3; eb[1] = 3; eb[2] = 3; eb[3] = 4; eb[4] = 5; eb[5] = 9;
        load_main();
        start_job(6);
        total++; if (busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL main_load_entry: busy=%b in_ready=%b want 1/1", busy, in_ready); end
        feed(6, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL main_in_ready_drop: got %b want 0", in_ready); end
        wait_done("main");
        total++; if (result !== 32'd11) begin bad++; $display("FAIL main_result: got %0d want 11", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL main_busy: got %b want 0", busy); end
        total++; if (sort_go_cnt - b_sort != 2 || sum_go_cnt - b_sum != 1) begin bad++; $display("FAIL main_go_pulses: sort=%0d sum=%0d want 2/1", sort_go_cnt - b_sort, sum_go_cnt - b_sum); end
        total++; if (sel_hist !== 2'b01) begin bad++; $display("FAIL main_sort_sel: got %b want 01", sel_hist); end
        total++; if (last_sort_len !== 16'd6 || last_sum_len !== 16'd5) begin bad++; $display("FAIL main_lengths: sort_len=%0d sum_length=%0d want 6/5", last_sort_len, last_sum_len); end
        total++; if (clr_cnt - b_clr != 1) begin bad++; $display("FAIL main_sum_clear: got %0d cycles want 1", clr_cnt - b_clr); end
        for (int i = 0; i < 6; i++)
            if (mem_a[4'(i)] !== ea[i] || mem_b[4'(i)] !== eb[i]) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL main_sorted_banks: got a0=%0d b5=%0d want 1/9", mem_a[0], mem_b[5]); end
        repeat (5) tick();
        total++; if (done !== 1'b1 || result !== 32'd11) begin bad++; $display("FAIL main_hold: done=%b result=%0d want 1/11", done, result); end
    endtask

    task automatic test_zero_len();
        int b_sort = sort_go_cnt, b_sum = sum_go_cnt, b_rdy = in_ready_cnt;
        start_job(0);
        tick();
        total++; if (done !== 1'b1 || result !== 32'd0) begin bad++; $display("FAIL zero_finish: done=%b result=%0d want 1/0", done, result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        tick();
        total++; if (in_ready_cnt != b_rdy || sort_go_cnt != b_sort || sum_go_cnt != b_sum) begin
            bad++; $display("FAIL zero_no_activity: in_ready=%0d sort_go=%0d sum_go=%0d want 0/0/0", in_ready_cnt - b_rdy, sort_go_cnt - b_sort, sum_go_cnt - b_sum);
        end
    endtask

    task automatic test_gapped_load();
        int ba = load_cnt_a, bb = load_cnt_b;
        va[0] = 5; va[1] = 1; va[2] = 9;
        vb[0] = 2; vb[1] = 8; vb[2] = 4;
        start_job(3);
        feed(3, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL gap_in_ready: got %b want 0", in_ready); end
        tick(); tick();
        total++; if (load_cnt_a - ba != 3 || load_cnt_b - bb != 3) begin bad++; $display("FAIL gap_write_count: a=%0d b=%0d want 3/3", load_cnt_a - ba, load_cnt_b - bb); end
        total++; if (load_log_a[6'(ba)] !== 16'd0 || load_log_a[6'(ba+1)] !== 16'd1 || load_log_a[6'(ba+2)] !== 16'd2 ||
                     load_log_b[6'(bb)] !== 16'd0 || load_log_b[6'(bb+1)] !== 16'd1 || load_log_b[6'(bb+2)] !== 16'd2) begin
            bad++; $display("FAIL gap_write_addr: a=%0d,%0d,%0d want 0,1,2", load_log_a[6'(ba)], load_log_a[6'(ba+1)], load_log_a[6'(ba+2)]);
        end
        wait_done("gap");
        total++; if (result !== 32'd3) begin bad++; $display("FAIL gap_result: got %0d want 3", result); end
    endtask

    task automatic test_start_during_sort_b();
        int b_rdy = in_ready_cnt, b_sort = sort_go_cnt, c = 0;
        load_main();
        start_job(6);
        feed(6, 1'b0);
        while (!(s_phase == 1 && s_sel) && c < 500) begin tick(); c++; end
        total++; if (!(s_phase == 1 && s_sel)) begin bad++; $display("FAIL sortb_reach: phase=%0d sel=%b want 1/1", s_phase, s_sel); end
        start = 1'b1; length = 16'd2;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL sortb_start_ignored: busy=%b done=%b want 1/0", busy, done); end
        wait_done("sortb");
        total++; if (result !== 32'd11) begin bad++; $display("FAIL sortb_result: got %0d want 11", result); end
        total++; if (in_ready_cnt - b_rdy != 6 || sort_go_cnt - b_sort != 2 || last_sum_len !== 16'd5) begin
            bad++; $display("FAIL sortb_no_relatch: in_ready=%0d sort_go=%0d sum_length=%0d want 6/2/5", in_ready_cnt - b_rdy, sort_go_cnt - b_sort, last_sum_len);
        end
    endtask

    task automatic test_spurious_sort_done();
        va[0] = 4; va[1] = 1;
        vb[0] = 1; vb[1] = 6;
        start_job(2);
        in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; spur_done = 1'b1;
        tick();
        spur_done = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL spur_stay_load: in_ready=%b busy=%b want 1/1", in_ready, busy); end
        in_valid = 1'b1; in_a = va[1]; in_b = vb[1];
        tick();
        in_valid = 1'b0;
        wait_done("spur");
        total++; if (result !== 32'd2) begin bad++; $display("FAIL spur_result: got %0d want 2", result); end
    endtask

    task automatic test_reset_mid_sum();
        int c = 0;
        load_main();
        start_job(6);
        feed(6, 1'b0);
        while (m_phase != 1 && c < 500) begin tick(); c++; end
        total++; if (m_phase != 1) begin bad++; $display("FAIL rstsum_reach: phase=%0d want 1", m_phase); end
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL rstsum_state: busy=%b done=%b result=%0d want 0/0/0", busy, done, result); end
        total++; if ({mema_we, memb_we, in_ready, sum_rst_n} !== 4'b0000) begin bad++; $display("FAIL rstsum_outputs: got %b want 0000", {mema_we, memb_we, in_ready, sum_rst_n}); end
        tick();
        reset = 1'b1;
        tick();
        va[0] = 7; vb[0] = 2;
        start_job(1);
        feed(1, 1'b0);
        wait_done("rstsum");
        total++; if (result !== 32'd5) begin bad++; $display("FAIL rstsum_new_job: got %0d want 5", result); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; length = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; spur_done = 1'b0;
        test_reset();
        test_main_job();
        test_zero_len();
        test_gapped_load();
        test_start_during_sort_b();
        test_spurious_sort_done();
        test_reset_mid_sum();
        total++; if (we_viol != 0) begin bad++; $display("FAIL bank_ownership: got %0d violations want 0", we_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
